// File: rtl/fft_pkg.sv
// Shared definitions for the streaming FFT stage controllers.
//   sdf_state_t      : stage controller sequencing states
//   TW_*             : twiddle coefficient format (signed fixed point, 8 fraction bits)
//   N_POINTS_DEFAULT : default transform length
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } sdf_state_t;

    // Twiddle words are TW_W bits wide with TW_FRAC fraction bits.
    // Index 0 of every twiddle ROM holds TW_ONE (W^0 = 1.0).
    localparam int          TW_W       = 24;
    localparam int          TW_FRAC    = 8;
    localparam logic [23:0] TW_ONE     = 24'h000100;
    localparam logic [23:0] TW_NEG_ONE = 24'hFFFF00;

    localparam int N_POINTS_DEFAULT = 256;

endpackage

// File: rtl/sdf_tw_addr_gen.sv
// Twiddle-ROM address generator for one radix-2 SDF stage.
// Purely combinational.
//   cnt       in  : low LOG2N-1 bits of the stage input position
//   phase     in  : stage phase (1 = butterfly half, 0 = pass-through half)
//   out_valid in  : stage output valid this cycle
//   tw_addr   out : twiddle index k for W_N^k; 0 (unity) unless phase = 0 and output is valid
module sdf_tw_addr_gen #(
    parameter int  N_POINTS = 256,
    parameter int  DELAY    = 64,
    localparam int LOG2N    = $clog2(N_POINTS)
) (
    input  logic [LOG2N-2:0] cnt,
    input  logic             phase,
    input  logic             out_valid,
    output logic [LOG2N-2:0] tw_addr
);
    // Stride between consecutive twiddle indices is N/(2*DELAY), a power of two.
    localparam int               LOG2D  = $clog2(DELAY);
    localparam int               LOG2S  = LOG2N - 1 - LOG2D;
    localparam logic [LOG2N-2:0] K_MASK = (LOG2N-1)'(DELAY - 1);

    logic [LOG2N-2:0] k_mod;

    // cnt mod DELAY; for DELAY = 1 the mask is zero and the index collapses to 0.
    assign k_mod = cnt & K_MASK;

    // The largest product, (DELAY-1) * N/(2*DELAY), is below N/2, so it fits.
    assign tw_addr = (out_valid && !phase) ? (k_mod << LOG2S) : '0;

endmodule

// File: rtl/sdf_stage_ctrl.sv
// Sequencing controller for one radix-2 single-path delay-feedback FFT stage.
// Counts accepted samples, decodes butterfly/pass-through select, drives the
// twiddle-ROM address, output valid/last, and drains the delay line on flush.
// All outputs are decoded combinationally from the registers and the current
// inputs, so the controls apply to the sample accepted in the same cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : input sample present
//   in_last    : last sample of a frame (qualified by in_valid)
//   flush      : one-cycle drain request after the final frame
//   in_ready   : stage accepts a sample this cycle (low while draining)
//   shift_en   : delay-line shift enable
//   bfly_sel   : 1 = butterfly, 0 = pass-through
//   tw_addr    : twiddle index k for W_N^k
//   out_valid  : stage output sample valid
//   out_last   : last output sample of a frame
//   busy       : controller not idle
//   frame_err  : sticky framing error (misplaced in_last or flush)
module sdf_stage_ctrl
    import fft_pkg::*;
#(
    parameter int  N_POINTS = N_POINTS_DEFAULT,
    parameter int  DELAY    = 64,
    localparam int LOG2N    = $clog2(N_POINTS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic             flush,
    output logic             in_ready,
    output logic             shift_en,
    output logic             bfly_sel,
    output logic [LOG2N-2:0] tw_addr,
    output logic             out_valid,
    output logic             out_last,
    output logic             busy,
    output logic             frame_err
);
    localparam int               LOG2D    = $clog2(DELAY);
    localparam logic [LOG2N-1:0] CNT_MAX  = LOG2N'(N_POINTS - 1);
    localparam logic [LOG2N-1:0] DLY_LAST = LOG2N'(DELAY - 1);

    sdf_state_t       state_reg, state_next;
    logic [LOG2N-1:0] cnt_reg, cnt_next;
    logic [LOG2N-1:0] ocnt_reg, ocnt_next;
    logic [LOG2N-1:0] dcnt_reg, dcnt_next;
    logic             frame_err_reg, frame_err_next;

    logic acc;
    logic draining;
    logic phase;
    logic flush_ok;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            ocnt_reg      <= '0;
            dcnt_reg      <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            ocnt_reg      <= ocnt_next;
            dcnt_reg      <= dcnt_next;
            frame_err_reg <= frame_err_next;
        end
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        draining  = (state_reg == DRAIN);
        in_ready  = !draining;
        acc       = in_valid && in_ready;
        shift_en  = acc || draining;
        // First half of each 2*DELAY block is pass-through, second half butterfly.
        phase     = cnt_reg[LOG2D];
        // Drain only covers cnt 0..DELAY-1, so phase is already 0 there;
        // forcing it keeps the drain select explicit.
        bfly_sel  = draining ? 1'b0 : phase;
        out_valid = draining || ((state_reg == RUN) && acc);
        out_last  = out_valid && (ocnt_reg == CNT_MAX);
        busy      = (state_reg != IDLE);
        frame_err = frame_err_reg;
        // Honour flush only on a frame boundary with no sample arriving.
        flush_ok  = flush && (state_reg == RUN) && (cnt_reg == '0) && !in_valid;
    end

    sdf_tw_addr_gen #(
        .N_POINTS (N_POINTS),
        .DELAY    (DELAY)
    ) u_tw_addr_gen (
        .cnt       (cnt_reg[LOG2N-2:0]),
        .phase     (phase),
        .out_valid (out_valid),
        .tw_addr   (tw_addr)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        ocnt_next      = ocnt_reg;
        dcnt_next      = dcnt_reg;
        frame_err_next = frame_err_reg;

        // N_POINTS is a power of two, so natural overflow is the wrap.
        if (acc || draining) begin
            cnt_next = cnt_reg + 1'b1;
        end

        // Misplaced in_last: flag it and resync the input position.
        if (acc && in_last && (cnt_reg != CNT_MAX)) begin
            frame_err_next = 1'b1;
            cnt_next       = '0;
        end

        if (out_valid) begin
            ocnt_next = ocnt_reg + 1'b1;
        end

        if (flush && !flush_ok) begin
            frame_err_next = 1'b1;
        end

        unique case (state_reg)
            IDLE, PRIME: begin
                // The sample accepted at cnt = DELAY-1 completes the fill;
                // with DELAY = 1 this happens on the very first sample.
                if (acc) begin
                    state_next = (cnt_reg == DLY_LAST) ? RUN : PRIME;
                end
            end
            RUN: begin
                if (flush_ok) begin
                    state_next = DRAIN;
                    dcnt_next  = '0;
                end
            end
            DRAIN: begin
                dcnt_next = dcnt_reg + 1'b1;
                if (dcnt_reg == DLY_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    ocnt_next  = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Self-checking bench for sdf_stage_ctrl. Two instances (DELAY = 64 and
// DELAY = 1, both N = 256) share one stimulus stream; each is compared every
// cycle against a per-instance behavioural model built from sample counts.
module tb_sdf_stage_ctrl;
    localparam int N  = 256;
    localparam int NI = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_last = 1'b0;
    logic flush = 1'b0;

    logic [NI-1:0] in_ready_w, shift_en_w, bfly_sel_w, out_valid_w, out_last_w, busy_w, frame_err_w;
    logic [6:0]    tw0, tw1;

    sdf_stage_ctrl #(.N_POINTS(N), .DELAY(64)) dut_d64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last), .flush(flush),
        .in_ready(in_ready_w[0]), .shift_en(shift_en_w[0]), .bfly_sel(bfly_sel_w[0]),
        .tw_addr(tw0), .out_valid(out_valid_w[0]), .out_last(out_last_w[0]),
        .busy(busy_w[0]), .frame_err(frame_err_w[0])
    );

    sdf_stage_ctrl #(.N_POINTS(N), .DELAY(1)) dut_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last), .flush(flush),
        .in_ready(in_ready_w[1]), .shift_en(shift_en_w[1]), .bfly_sel(bfly_sel_w[1]),
        .tw_addr(tw1), .out_valid(out_valid_w[1]), .out_last(out_last_w[1]),
        .busy(busy_w[1]), .frame_err(frame_err_w[1])
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check_val(input string tag, input int inst, input logic [31:0] obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s inst%0d cyc %0d: got %0d expected %0d", tag, inst, cyc, obs, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // pos   : position of the next input sample within its frame
    // tot   : samples accepted since the stream started (fill needs DELAY)
    // ocnt  : outputs produced so far, mod N
    // drain : drain cycles remaining
    int m_pos[NI], m_tot[NI], m_ocnt[NI], m_drain[NI];
    bit m_ferr[NI];

    function automatic int dly(input int i);
        return (i == 0) ? 64 : 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_pos[i] = 0; m_tot[i] = 0; m_ocnt[i] = 0; m_drain[i] = 0; m_ferr[i] = 0;
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < NI; i++) begin
            int d      = dly(i);
            int stride = N / (2 * d);
            bit dr     = (m_drain[i] > 0);
            bit ph     = ((m_pos[i] / d) % 2) == 1;
            bit e_rdy  = !dr;
            bit e_acc  = in_valid && e_rdy;
            bit e_ov   = dr || (e_acc && m_tot[i] >= d);
            bit e_bf   = dr ? 1'b0 : ph;
            int e_tw   = (e_ov && !ph) ? (m_pos[i] % d) * stride : 0;
            bit e_last = e_ov && (m_ocnt[i] == N - 1);
            bit e_busy = dr || (m_tot[i] > 0);
            logic [6:0] tw = (i == 0) ? tw0 : tw1;
            check_val("in_ready",  i, 32'(in_ready_w[i]),  int'(e_rdy));
            check_val("shift_en",  i, 32'(shift_en_w[i]),  int'(e_acc || dr));
            check_val("bfly_sel",  i, 32'(bfly_sel_w[i]),  int'(e_bf));
            check_val("tw_addr",   i, 32'(tw),             e_tw);
            check_val("out_valid", i, 32'(out_valid_w[i]), int'(e_ov));
            check_val("out_last",  i, 32'(out_last_w[i]),  int'(e_last));
            check_val("busy",      i, 32'(busy_w[i]),      int'(e_busy));
            check_val("frame_err", i, 32'(frame_err_w[i]), int'(m_ferr[i]));
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < NI; i++) begin
            int d     = dly(i);
            bit dr    = (m_drain[i] > 0);
            bit acc   = in_valid && !dr;
            bit ov    = dr || (acc && m_tot[i] >= d);
            bit start = 1'b0;
            if (flush) begin
                if (!dr && m_tot[i] >= d && m_pos[i] == 0 && !in_valid) start = 1'b1;
                else m_ferr[i] = 1'b1;
            end
            if (dr) begin
                m_pos[i]  = (m_pos[i] + 1) % N;
                m_ocnt[i] = (m_ocnt[i] + 1) % N;
                m_drain[i]--;
                if (m_drain[i] == 0) begin
                    m_pos[i] = 0; m_ocnt[i] = 0; m_tot[i] = 0;
                end
            end else if (acc) begin
                if (ov) m_ocnt[i] = (m_ocnt[i] + 1) % N;
                if (in_last && m_pos[i] != N - 1) begin
                    m_ferr[i] = 1'b1;
                    m_pos[i]  = 0;
                end else begin
                    m_pos[i] = (m_pos[i] + 1) % N;
                end
                m_tot[i]++;
            end
            if (start) m_drain[i] = d;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    bit track = 1'b0;
    int acc_idx = 0;
    int first_ov = -1;
    int n_last[NI];

    task automatic cycle(input bit v, input bit l, input bit f);
        in_valid = v; in_last = l; flush = f;
        @(negedge clk);
        check_outputs();
        if (track) begin
            if (out_valid_w[0] && first_ov < 0) first_ov = acc_idx;
            for (int i = 0; i < NI; i++) if (out_last_w[i]) n_last[i]++;
            if (in_valid && in_ready_w[0]) acc_idx++;
        end
        model_update();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Sends n accepted samples with gap_pct% idle cycles; in_last on sample last_at.
    task automatic send_samples(input int n, input int gap_pct, input int last_at);
        int sent = 0;
        int guard = 0;
        while (sent < n && guard < 20 * n + 100) begin
            guard++;
            if (int'($urandom_range(99)) < gap_pct) begin
                cycle(1'b0, 1'($urandom_range(1)), 1'b0);
            end else begin
                cycle(1'b1, sent == last_at, 1'b0);
                sent++;
            end
        end
        if (sent < n) check_val("send_budget", 0, 32'(sent), n);
    endtask

    task automatic do_reset();
        in_valid = 1'b0; in_last = 1'b0; flush = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #2;
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;
        cyc++;
    endtask

    initial begin
        n_last[0] = 0; n_last[1] = 0;
        model_reset();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        $display("reset: checks so far %0d", checks);

        // Two contiguous frames, flush on the boundary, then the drain.
        track = 1'b1;
        send_samples(N, 0, N - 1);
        send_samples(N, 0, N - 1);
        cycle(1'b0, 1'b0, 1'b1);
        repeat (64) cycle(1'b0, 1'b0, 1'b0);
        track = 1'b0;
        repeat (4) cycle(1'b0, 1'b0, 1'b0);
        check_val("first_out_sample", 0, 32'(first_ov), 64);
        check_val("out_last_count", 0, 32'(n_last[0]), 2);
        check_val("out_last_count", 1, 32'(n_last[1]), 2);
        check_val("idle_after_drain", 0, 32'(busy_w[0]), 0);
        $display("contiguous frames + drain: checks %0d errors %0d", checks, errors);

        // Random gaps over a frame, then reset partway through the next.
        send_samples(N, 50, N - 1);
        send_samples(100, 50, -1);
        do_reset();
        $display("gapped frame + mid-run reset: checks %0d errors %0d", checks, errors);

        // Misplaced in_last at cnt = 100, then a clean frame, then flush/drain.
        send_samples(101, 30, 100);
        send_samples(N, 30, N - 1);
        check_val("frame_err_sticky", 0, 32'(frame_err_w[0]), 1);
        cycle(1'b0, 1'b0, 1'b1);
        repeat (66) cycle(1'b0, 1'b0, 1'b0);
        $display("framing error + clean frame + drain: checks %0d errors %0d", checks, errors);

        // Misplaced flush requests: in IDLE, and in RUN off the frame boundary.
        do_reset();
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        do_reset();
        send_samples(80, 20, -1);
        cycle(1'b0, 1'b0, 1'b1);
        send_samples(20, 20, -1);
        $display("misplaced flush: checks %0d errors %0d", checks, errors);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout at cyc %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sdf_stage_ctrl.md
Name: sdf_stage_ctrl

Overview:
- Sequencing controller for one radix-2 single-path delay-feedback (SDF) stage of the 256-point streaming FFT.
- Counts accepted samples and decodes the per-cycle butterfly/pass-through select.
- Generates the twiddle-ROM address for the stage's complex multiplier, output valid/last, and the end-of-stream drain.
- One instance per stage, placed between the stage input stream and that stage's delay line, butterfly and twiddle ROM.

Parameters:
- N_POINTS, 256, FFT length; power of two, ≥4.
- DELAY, 64, stage delay-line depth; power of two, 1 ≤ DELAY ≤ N_POINTS/2.
- LOG2N, $clog2(N_POINTS), counter width; derived, not overridden.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active-low.
- in_valid  in  1  input sample present this cycle.
- in_last  in  1  qualifies the last sample of a frame; meaningful only with in_valid.
- flush  in  1  single-cycle request to drain the delay line after the final frame.
- in_ready  out  1  stage accepts a sample this cycle.
- shift_en  out  1  delay-line shift enable.
- bfly_sel  out  1  1 = butterfly (sum to output, difference to delay line); 0 = pass-through (input to delay line, delay-line head to output).
- tw_addr  out  LOG2N-1  twiddle index k, for W_N^k.
- out_valid  out  1  stage output sample valid.
- out_last  out  1  last output sample of a frame.
- busy  out  1  state ≠ IDLE.
- frame_err  out  1  sticky framing error.

Behaviour:
- Reset is asynchronous, active-low, on rst_n; clock is clk.
- Reset values:
  - state = IDLE; cnt = 0; ocnt = 0; frame_err = 0.
  - Outputs: in_ready = 1, shift_en = 0, bfly_sel = 0, tw_addr = 0, out_valid = 0, out_last = 0, busy = 0.
- Registers: cnt (LOG2N bits, input position), ocnt (LOG2N bits, output position), dcnt (drain counter), state.
- All outputs are combinationally decoded from the registers and the current inputs. Zero latency: the controls apply to the sample accepted in the same cycle.
- Accept: acc = in_valid && in_ready.
  - On acc, cnt wraps from N_POINTS-1 to 0.
  - shift_en = acc || (state == DRAIN).
- Phase: phase = cnt[log2(DELAY)]. bfly_sel = phase, in all states, on the accepted or drain cycle.
- Twiddle:
  - When phase = 0 and output is valid: tw_addr = (cnt mod DELAY) * (N_POINTS/(2*DELAY)).
  - Otherwise tw_addr = 0, i.e. W^0 = 1.0, Q.8 format 24'h000100.
- States:
  - IDLE: the first acc moves to PRIME.
  - PRIME: out_valid = 0. After DELAY accepted samples in total, move to RUN. Stream latency is exactly DELAY accepted samples.
  - RUN: out_valid = acc. ocnt increments on every out_valid and wraps at N_POINTS-1. out_last = out_valid && ocnt == N_POINTS-1.
    - flush is honoured only in RUN with cnt == 0, and only when flush && !in_valid; the FSM then moves to DRAIN with dcnt = 0.
    - flush in any other state or position is ignored and sets frame_err.
  - DRAIN:
    - in_ready = 0; out_valid = 1 every cycle; bfly_sel = 0; cnt advances as if a sample were accepted.
    - After DELAY cycles, return to IDLE; cnt = 0 and ocnt = 0 at that point.
- Framing check:
  - If in_last is accepted with cnt ≠ N_POINTS-1, set frame_err and force cnt to 0 next cycle (resync). ocnt is unaffected.
  - in_last accepted with cnt = N_POINTS-1 is the normal case; no action.
- Back-to-back frames stream without bubbles. The fill phase of frame n+1 pushes out the differences of frame n.
- Gaps (in_valid = 0 in PRIME or RUN): no counter or delay-line movement; all outputs hold their decoded values with out_valid = 0.
- frame_err clears only on reset.
- Reset mid-frame or mid-drain: immediate return to reset values; delay-line contents are don't-care.

Decomposition:
- Shared package fft_pkg contains:
  - state enum {IDLE, PRIME, RUN, DRAIN};
  - twiddle format constants: TW_W = 24, TW_FRAC = 8, TW_ONE = 24'h000100, TW_NEG_ONE = 24'hFFFF00;
  - N_POINTS_DEFAULT = 256.
- One sub-module, sdf_tw_addr_gen: combinational mapping (cnt, phase, out_valid) → tw_addr, parameterised by N_POINTS and DELAY. It is reused by the other stage controllers.

Test Plan:
- Reset with rst_n = 0 mid-run → next edge: out_valid = 0, busy = 0, in_ready = 1, cnt = 0, frame_err = 0.
- DELAY = 64: 256 contiguous samples, in_last on #255 → out_valid first high on sample #64. bfly_sel = 1 for cnt 64..127 and 192..255. tw_addr = 2k for k = 0..63 on cnt 128..191. tw_addr = 0 on cnt 64..127.
- Two back-to-back frames, then flush at cnt = 0 → 64 DRAIN cycles with in_ready = 0 and tw_addr = 0,2,…,126. out_last fires at total output #255 and #511. Then busy = 0.
- Random in_valid gaps (50%) over one frame → identical bfly_sel, tw_addr and out_valid sequence per accepted sample as the gap-free run.
- in_last asserted at cnt = 100 → frame_err = 1, cnt = 0 on the next cycle. frame_err stays 1 through a subsequent clean frame.
- DELAY = 1, N_POINTS = 256 → bfly_sel toggles every accepted sample. tw_addr = 0 on even (pass-through) cycles, since the stride-128 index is 0. Drain lasts 1 cycle.
